// File: rtl/control_seq_pkg.sv
// Shared CPU definitions: instruction field positions, opcodes, control-FSM
// state encoding and opcode classification used by the control sequencer.
package control_seq_pkg;

  localparam int unsigned IR_W  = 32;
  localparam int unsigned OP_W  = 5;
  localparam int unsigned REG_W = 4;
  localparam int unsigned NREG  = 16;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  localparam logic [OP_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR  = 5'b00110;
  localparam logic [OP_W-1:0] OP_DIV = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL = 5'b10000;

  typedef enum logic [2:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6
  } state_e;

  typedef enum logic [1:0] {
    CLS_3REG, CLS_HILO, CLS_ILL
  } op_class_e;

  function automatic op_class_e op_class(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return CLS_3REG;
      OP_DIV, OP_MUL:                return CLS_HILO;
      default:                       return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/control_seq_sel_encode.sv
// Register-field decoder: 4-bit register number plus enable to a one-hot
// 16-bit select; all-zero when disabled.
module sel_encode
  import control_seq_pkg::*;
(
  input  logic [REG_W-1:0] i_sel,
  input  logic             i_en,
  output logic [NREG-1:0]  o_onehot
);

  assign o_onehot = i_en ? (NREG'(1) << i_sel) : '0;

endmodule

// File: rtl/control_seq.sv
// Hardwired control sequencer: fetch (T0-T2) then per-class execute steps.
// Outputs are Moore-decoded from the current state and the loaded ir.
module control_seq
  import control_seq_pkg::*;
(
  input  logic            clock,
  input  logic            clear,
  input  logic            run,
  input  logic [IR_W-1:0] ir,
  output logic            PCout,
  output logic            MARin,
  output logic            incPC,
  output logic            PCin,
  output logic            read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            ZLowOut,
  output logic            ZHighOut,
  output logic            HIin,
  output logic            LOin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic [OP_W-1:0] opcode,
  output logic            done,
  output logic            illegal
);

  state_e           r_state;
  state_e           w_next;
  logic [OP_W-1:0]  w_op;
  logic [REG_W-1:0] w_ra;
  logic [REG_W-1:0] w_rb;
  logic [REG_W-1:0] w_rc;
  op_class_e        w_cls;
  logic             w_rin_en;
  logic             w_rout_en;
  logic [REG_W-1:0] w_rout_sel;
  logic             w_unused_ir;

  assign w_op        = ir[OP_MSB:OP_LSB];
  assign w_ra        = ir[RA_MSB:RA_LSB];
  assign w_rb        = ir[RB_MSB:RB_LSB];
  assign w_rc        = ir[RC_MSB:RC_LSB];
  assign w_cls       = op_class(w_op);
  assign w_unused_ir = ^ir[RC_LSB-1:0];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and strobe decode; every instruction end returns to T0 or IDLE on run.
  always_comb begin
    w_next     = r_state;
    PCout      = 1'b0;
    MARin      = 1'b0;
    incPC      = 1'b0;
    PCin       = 1'b0;
    read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    ZLowOut    = 1'b0;
    ZHighOut   = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    opcode     = '0;
    done       = 1'b0;
    illegal    = 1'b0;
    w_rin_en   = 1'b0;
    w_rout_en  = 1'b0;
    w_rout_sel = '0;
    case (r_state)
      ST_IDLE: if (run) w_next = ST_T0;
      ST_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        incPC  = 1'b1;
        w_next = ST_T1;
      end
      ST_T1: begin
        PCin   = 1'b1;
        read   = 1'b1;
        MDRin  = 1'b1;
        w_next = ST_T2;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        w_next = ST_T3;
      end
      ST_T3: begin
        if (w_cls == CLS_ILL) begin
          illegal = 1'b1;
          w_next  = run ? ST_T0 : ST_IDLE;
        end else begin
          w_rout_en  = 1'b1;
          w_rout_sel = (w_cls == CLS_3REG) ? w_rb : w_ra;
          Yin        = 1'b1;
          w_next     = ST_T4;
        end
      end
      ST_T4: begin
        w_rout_en  = 1'b1;
        w_rout_sel = (w_cls == CLS_3REG) ? w_rc : w_rb;
        opcode     = w_op;
        Zin        = 1'b1;
        w_next     = ST_T5;
      end
      ST_T5: begin
        ZLowOut = 1'b1;
        if (w_cls == CLS_HILO) begin
          LOin   = 1'b1;
          w_next = ST_T6;
        end else begin
          w_rin_en = 1'b1;
          done     = 1'b1;
          w_next   = run ? ST_T0 : ST_IDLE;
        end
      end
      ST_T6: begin
        ZHighOut = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
        w_next   = run ? ST_T0 : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  sel_encode u_rin_enc (
    .i_sel    (w_ra),
    .i_en     (w_rin_en),
    .o_onehot (Rin)
  );

  sel_encode u_rout_enc (
    .i_sel    (w_rout_sel),
    .i_en     (w_rout_en),
    .o_onehot (Rout)
  );

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq: expected strobe vectors are queued per
// step as instructions are issued and compared at each falling clock edge.
module tb_control_seq;

  typedef struct packed {
    logic        pc_out, mar_in, inc_pc, pc_in, rd, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, zlo_out, zhi_out, hi_in, lo_in;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  op;
    logic        done;
    logic        ill;
  } ctl_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        run;
  logic [31:0] ir;
  logic        PCout, MARin, incPC, PCin, read, MDRin, MDRout, IRin;
  logic        Yin, Zin, ZLowOut, ZHighOut, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic [4:0]  opcode;
  logic        done, illegal;

  ctl_t  obs;
  ctl_t  exp_q[$];
  string tag_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  control_seq dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir),
    .PCout(PCout), .MARin(MARin), .incPC(incPC), .PCin(PCin), .read(read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin),
    .Rin(Rin), .Rout(Rout), .opcode(opcode), .done(done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  always_comb begin
    obs = '0;
    obs.pc_out = PCout;   obs.mar_in = MARin;    obs.inc_pc = incPC;
    obs.pc_in  = PCin;    obs.rd     = read;     obs.mdr_in = MDRin;
    obs.mdr_out = MDRout; obs.ir_in  = IRin;     obs.y_in   = Yin;
    obs.z_in   = Zin;     obs.zlo_out = ZLowOut; obs.zhi_out = ZHighOut;
    obs.hi_in  = HIin;    obs.lo_in  = LOin;     obs.rin    = Rin;
    obs.rout   = Rout;    obs.op     = opcode;   obs.done   = done;
    obs.ill    = illegal;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
  endtask

  task automatic push(input string tag, input ctl_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  function automatic ctl_t fetch(input int s);
    ctl_t c;
    c = '0;
    case (s)
      0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; end
      1: begin c.pc_in = 1'b1; c.rd = 1'b1; c.mdr_in = 1'b1; end
      default: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
    endcase
    return c;
  endfunction

  // Independent reference: expected strobes for each step of one instruction.
  task automatic push_model(input logic [31:0] instr, output int n);
    ctl_t c;
    logic [4:0] op;
    logic [15:0] ra1, rb1, rc1;
    bit three, hilo;
    op    = instr[31:27];
    ra1   = 16'h1 << instr[26:23];
    rb1   = 16'h1 << instr[22:19];
    rc1   = 16'h1 << instr[18:15];
    three = (op == 5'd3) || (op == 5'd4) || (op == 5'd5) || (op == 5'd6);
    hilo  = (op == 5'd15) || (op == 5'd16);
    for (int s = 0; s < 3; s++) push($sformatf("mdl_t%0d", s), fetch(s));
    c = '0;
    if (!three && !hilo) begin
      c.ill = 1'b1;
      push("mdl_t3_ill", c);
      n = 4;
      return;
    end
    c.rout = three ? rb1 : ra1; c.y_in = 1'b1;
    push("mdl_t3", c);
    c = '0; c.rout = three ? rc1 : rb1; c.op = op; c.z_in = 1'b1;
    push("mdl_t4", c);
    c = '0; c.zlo_out = 1'b1;
    if (three) begin
      c.rin = ra1; c.done = 1'b1;
      push("mdl_t5", c);
      n = 6;
    end else begin
      c.lo_in = 1'b1;
      push("mdl_t5", c);
      c = '0; c.zhi_out = 1'b1; c.hi_in = 1'b1; c.done = 1'b1;
      push("mdl_t6", c);
      n = 7;
    end
  endtask

  task automatic push_add();
    ctl_t c;
    for (int s = 0; s < 3; s++) push($sformatf("add_t%0d", s), fetch(s));
    c = '0; c.rout = 16'h0008; c.y_in = 1'b1;                       push("add_t3", c);
    c = '0; c.rout = 16'h0080; c.op = 5'b00011; c.z_in = 1'b1;      push("add_t4", c);
    c = '0; c.zlo_out = 1'b1; c.rin = 16'h0010; c.done = 1'b1;      push("add_t5", c);
  endtask

  task automatic push_mul(input int upto);
    ctl_t c[7];
    for (int s = 0; s < 3; s++) c[s] = fetch(s);
    c[3] = '0; c[3].rout = 16'h0004; c[3].y_in = 1'b1;
    c[4] = '0; c[4].rout = 16'h0040; c[4].op = 5'b10000; c[4].z_in = 1'b1;
    c[5] = '0; c[5].zlo_out = 1'b1; c[5].lo_in = 1'b1;
    c[6] = '0; c[6].zhi_out = 1'b1; c[6].hi_in = 1'b1; c[6].done = 1'b1;
    for (int s = 0; s <= upto; s++) push($sformatf("mul_t%0d", s), c[s]);
  endtask

  // One cycle: sample at the falling edge, compare head of scoreboard, check exclusivity.
  task automatic sample();
    int drv;
    @(negedge clock);
    drv = $countones(Rout) + int'(PCout) + int'(MDRout) + int'(ZLowOut) + int'(ZHighOut);
    check("bus_excl", 64'(drv > 1), 64'd0);
    check("rin_onehot", 64'($countones(Rin) > 1), 64'd0);
    if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size()), 64'd1);
    else check(tag_q.pop_front(), 64'(obs), 64'(exp_q.pop_front()));
  endtask

  task automatic run_steps(input logic [31:0] instr, input int n, input int drop_at);
    for (int s = 0; s < n; s++) begin
      sample();
      if (s == 2) ir = instr;
      if (s == drop_at) run = 1'b0;
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      push(tag, ctl_t'('0));
      sample();
    end
  endtask

  localparam logic [31:0] I_ADD = 32'h1A1B8000;
  localparam logic [31:0] I_MUL = 32'h81300000;
  localparam logic [31:0] I_ILL = 32'hF8000000;

  initial begin
    int n;
    logic [4:0] ops[8];
    logic [31:0] instr;
    ops[0] = 5'd3; ops[1] = 5'd4; ops[2] = 5'd5; ops[3] = 5'd6;
    ops[4] = 5'd15; ops[5] = 5'd16; ops[6] = 5'd0; ops[7] = 5'd31;

    clear = 1'b1; run = 1'b0; ir = 32'h0;
    push("rst_hold0", ctl_t'('0)); sample();
    run = 1'b1;
    push("rst_hold_run", ctl_t'('0)); sample();
    run = 1'b0; clear = 1'b0;
    idle(2, "rst_release");
    run = 1'b1;

    push_add();     run_steps(I_ADD, 6, -1);
    push_mul(6);    run_steps(I_MUL, 7, -1);
    push_model(I_ILL, n); run_steps(I_ILL, n, -1);
    push_add();     run_steps(I_ADD, 6, 1);
    idle(3, "idle_after_drop");

    run = 1'b1;
    push_mul(4);    run_steps(I_MUL, 5, -1);
    #1 clear = 1'b1; run = 1'b0;
    #1 check("clr_async", 64'(obs), 64'd0);
    push("clr_hold", ctl_t'('0)); sample();
    clear = 1'b0;
    idle(4, "clr_after");

    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instr = $urandom;
      instr[31:27] = ops[$urandom_range(0, 7)];
      push_model(instr, n);
      run_steps(instr, n, (i == 9) ? 0 : -1);
    end
    idle(2, "idle_end");

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 clock  in  1  single system clock; all state changes on rising edge.
REQ-002 clear  in  1  reset, asynchronous, active-high.
REQ-003 run  in  1  level; high permits starting a new instruction fetch.
REQ-004 ir  in  32  instruction register contents: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-005 PCout, MARin, incPC, PCin, read, MDRin, MDRout, IRin  out  1 each  fetch strobes to datapath.
REQ-006 Yin, Zin, ZLowOut, ZHighOut, HIin, LOin  out  1 each  ALU/result strobes to datapath.
REQ-007 Rin  out  16  one-hot general-register load enables R0..R15.
REQ-008 Rout  out  16  one-hot general-register bus-drive enables R0..R15.
REQ-009 opcode  out  5  ALU operation select.
REQ-010 done  out  1  one-cycle pulse in final step of a completed instruction.
REQ-011 illegal  out  1  one-cycle pulse when the decoded opcode is unsupported.

Function
REQ-012 Control FSM SHALL have states IDLE, T0..T6, one state per clock; all outputs Moore, decoded from state and ir only.
REQ-013 IDLE: all strobes 0; go to T0 when run=1, else stay.
REQ-014 T0: PCout=1, MARin=1, incPC=1; next T1.
REQ-015 T1: PCin=1, read=1, MDRin=1; next T2.
REQ-016 T2: MDRout=1, IRin=1; next T3; ir SHALL be treated as valid from T3 onward.
REQ-017 Supported opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110 (3-register class); DIV 01111, MUL 10000 (HI/LO class); all others illegal.
REQ-018 T3 3-register: Rout=onehot(Rb), Yin=1; HI/LO class: Rout=onehot(Ra), Yin=1.
REQ-019 T3 illegal: illegal=1, no other strobes; next T0 if run=1 else IDLE.
REQ-020 T4: Rout=onehot(Rc) for 3-register, onehot(Rb) for HI/LO class; opcode=ir[31:27]; Zin=1; next T5.
REQ-021 opcode output SHALL be 5'b00000 in every state other than T4.
REQ-022 T5 3-register: ZLowOut=1, Rin=onehot(Ra), done=1; next T0 if run=1 else IDLE.
REQ-023 T5 HI/LO class: ZLowOut=1, LOin=1; next T6.
REQ-024 T6: ZHighOut=1, HIin=1, done=1; next T0 if run=1 else IDLE.
REQ-025 Latency: 3-register instruction 6 cycles T0..T5; HI/LO instruction 7 cycles T0..T6; back-to-back with run held high, no idle cycle between instructions.
REQ-026 run deasserted mid-instruction SHALL NOT abort; instruction completes, then IDLE.
REQ-027 In every state at most one bus driver (any Rout bit, PCout, MDRout, ZLowOut, ZHighOut) SHALL be 1; Rin and Rout each at most one bit set.
REQ-028 Ra/Rb/Rc = 0 selects R0 as an ordinary register; Ra=Rb (or Rb=Rc) SHALL be permitted, with no special handling.

Reset
REQ-029 clear=1 SHALL force IDLE immediately, asynchronous to clock, aborting any instruction in progress.
REQ-030 While clear=1 and in the first cycle after release, every output SHALL be 0 (Rin=Rout=16'h0000, opcode=5'b00000).
REQ-031 After clear falls, T0 SHALL be entered on the first rising edge with run=1.

Structure
REQ-032 Opcode constants, state encodings and ir field bit positions SHALL live in the shared cpu package/header used by the datapath and ALU.
REQ-033 One sub-module, sel_encode, SHALL map a 4-bit register field plus enable to a 16-bit one-hot vector, instantiated once for Rin and once for Rout.

Verification
REQ-034 run=1, ir=0x1A1B8000 (ADD R4,R3,R7): T3 Rout=0x0008+Yin; T4 Rout=0x0080, opcode=00011, Zin; T5 ZLowOut, Rin=0x0010, done; 6 cycles.
REQ-035 run=1, ir=0x81300000 (MUL R2,R6): T3 Rout=0x0004+Yin; T4 Rout=0x0040, opcode=10000; T5 ZLowOut+LOin; T6 ZHighOut+HIin+done; 7 cycles.
REQ-036 ir opcode=11111: T3 illegal=1, all other strobes 0; T0 on next edge with run=1.
REQ-037 clear pulsed at T4 of MUL: IDLE immediately, all outputs 0, no LOin/HIin ever asserted for that instruction.
REQ-038 run dropped during T1 of ADD: instruction completes through T5 with done=1, then IDLE holds; bus-driver exclusivity asserted every cycle throughout.
